// File: rtl/secded_stream_decoder.sv
// secded_stream_decoder
//   Two-stage pipelined SECDED (39,32) decoder with valid/ready handshakes.
//   Codeword: in_code[i], i=1..38, is Hamming position i; check bits sit at
//   positions 1,2,4,8,16,32, data bits 0..31 fill the remaining positions in
//   ascending order; in_code[0] is even parity over in_code[38:1].
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_code[38:0]     received codeword
//   in_valid/in_ready input handshake
//   out_data[31:0]    corrected data (raw data field when out_ded=1)
//   out_synd[6:0]     {overall parity, 6-bit Hamming syndrome}
//   out_sec, out_ded  single-error-corrected / uncorrectable flags
//   out_valid/out_ready output handshake
//   cnt_clr           synchronous clear of the error counters
//   cnt_sec, cnt_ded  saturating 16-bit error counters
//
// Configuration
//   SECDED_ERR_CNT_EN  when defined, adds cnt_sec/cnt_ded and counter logic.
`timescale 1ns/1ps

module secded_stream_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [38:0] in_code,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [6:0]  out_synd,
    output logic        out_sec,
    output logic        out_ded,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        cnt_clr
`ifdef SECDED_ERR_CNT_EN
    ,
    output logic [15:0] cnt_sec,
    output logic [15:0] cnt_ded
`endif
);

    // Pull the 32 data bits out of the non-power-of-two positions 3..38.
    function automatic logic [31:0] extract_data(input logic [38:0] code);
        logic [31:0] d;
        int unsigned j;
        d = '0;
        j = 0;
        for (int unsigned i = 3; i <= 38; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j[4:0]] = code[i[5:0]];
                j++;
            end
        end
        return d;
    endfunction

    // Stage 1 state
    logic        s1_valid;
    logic [38:0] s1_code;
    logic [5:0]  s1_s;
    logic        s1_p;

    // Combinational syndrome of the incoming word
    logic [5:0]  in_s;
    logic        in_p;

    // Stage 2 next-state values
    logic [38:0] fixed_code;
    logic [31:0] s2_data;
    logic        s2_sec;
    logic        s2_ded;
    logic        s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    always_comb begin
        in_s = '0;
        for (int unsigned i = 1; i <= 38; i++) begin
            if (in_code[i[5:0]]) begin
                in_s = in_s ^ i[5:0];
            end
        end
        in_p = ^in_code;
    end

    // p=1 with s=0 is an error in the overall parity bit itself: counted as
    // corrected, data untouched. s>38 points outside the codeword, so it can
    // only arise from a multi-bit error.
    always_comb begin
        fixed_code = s1_code;
        s2_sec     = 1'b0;
        s2_ded     = 1'b0;
        if (s1_p) begin
            if (s1_s <= 6'd38) begin
                s2_sec = 1'b1;
                if (s1_s != 6'd0) begin
                    fixed_code[s1_s] = ~s1_code[s1_s];
                end
            end else begin
                s2_ded = 1'b1;
            end
        end else if (s1_s != 6'd0) begin
            s2_ded = 1'b1;
        end
        s2_data = extract_data(fixed_code);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_s     <= '0;
            s1_p     <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_code  <= in_code;
            s1_s     <= in_s;
            s1_p     <= in_p;
        end
    end

    // Flags are qualified with s1_valid so an empty S2 always shows 0 flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_synd  <= '0;
            out_sec   <= 1'b0;
            out_ded   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            out_data  <= s2_data;
            out_synd  <= {s1_p, s1_s};
            out_sec   <= s1_valid && s2_sec;
            out_ded   <= s1_valid && s2_ded;
        end
    end

`ifdef SECDED_ERR_CNT_EN
    logic xfer;
    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_sec <= '0;
            cnt_ded <= '0;
        end else if (cnt_clr) begin
            cnt_sec <= '0;
            cnt_ded <= '0;
        end else begin
            if (xfer && out_sec && (cnt_sec != '1)) begin
                cnt_sec <= cnt_sec + 16'd1;
            end
            if (xfer && out_ded && (cnt_ded != '1)) begin
                cnt_ded <= cnt_ded + 16'd1;
            end
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_secded_stream_decoder.sv
`timescale 1ns/1ps

module tb_secded_stream_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [38:0] in_code = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [6:0]  out_synd;
    logic        out_sec;
    logic        out_ded;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;
`ifdef SECDED_ERR_CNT_EN
    logic [15:0] cnt_sec;
    logic [15:0] cnt_ded;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    secded_stream_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_synd  (out_synd),
        .out_sec   (out_sec),
        .out_ded   (out_ded),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr)
`ifdef SECDED_ERR_CNT_EN
        ,
        .cnt_sec   (cnt_sec),
        .cnt_ded   (cnt_ded)
`endif
    );

    // Reference Hamming(38)+overall-parity encoder.
    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] c;
        int j;
        logic par;
        c = '0;
        j = 0;
        for (int i = 1; i <= 38; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            par = 1'b0;
            for (int i = 1; i <= 38; i++) begin
                if (((i >> k) & 1) == 1 && i != (1 << k)) par = par ^ c[i];
            end
            c[1 << k] = par;
        end
        c[0] = ^c[38:1];
        return c;
    endfunction

    // Stimulus only: drives one word at a negedge with out_ready=1 and returns
    // what appears on the output plus the latency in cycles (-1 on timeout).
    task automatic run_word(input logic [38:0] code, output logic [31:0] d,
                            output logic [6:0] sy, output logic sec,
                            output logic ded, output int lat);
        d = '0; sy = '0; sec = 1'b0; ded = 1'b0; lat = -1;
        in_code = code; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                d = out_data; sy = out_synd; sec = out_sec; ded = out_ded; lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (out_synd !== 7'd0) begin n_fail++; $display("FAIL reset_out_synd: got %b expected 0", out_synd); end
        n_checks++; if (out_sec !== 1'b0 || out_ded !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got sec=%b ded=%b expected 0 0", out_sec, out_ded); end
`ifdef SECDED_ERR_CNT_EN
        n_checks++; if (cnt_sec !== 16'd0 || cnt_ded !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d expected 0 0", cnt_sec, cnt_ded); end
`endif
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_clean();
        logic [31:0] d; logic [6:0] sy; logic sec, ded; int lat;
        run_word(encode(32'd8456), d, sy, sec, ded, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL clean_latency: got %0d expected 2", lat); end
        n_checks++; if (d !== 32'd8456) begin n_fail++; $display("FAIL clean_data: got %0d expected 8456", d); end
        n_checks++; if (sy !== 7'd0) begin n_fail++; $display("FAIL clean_synd: got %b expected 0000000", sy); end
        n_checks++; if (sec !== 1'b0 || ded !== 1'b0) begin n_fail++; $display("FAIL clean_flags: got sec=%b ded=%b expected 0 0", sec, ded); end
        @(negedge clk);
`ifdef SECDED_ERR_CNT_EN
        n_checks++; if (cnt_sec !== 16'd0) begin n_fail++; $display("FAIL clean_cnt_sec: got %0d expected 0", cnt_sec); end
`endif
    endtask

    task automatic test_single();
        logic [31:0] d; logic [6:0] sy; logic sec, ded; int lat;
        logic [38:0] code;
        code = encode(32'd8456);
        code[13] = ~code[13];
        run_word(code, d, sy, sec, ded, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", lat); end
        n_checks++; if (d !== 32'd8456) begin n_fail++; $display("FAIL single_data: got %0d expected 8456", d); end
        n_checks++; if (sy !== 7'b1001101) begin n_fail++; $display("FAIL single_synd: got %b expected 1001101", sy); end
        n_checks++; if (sec !== 1'b1 || ded !== 1'b0) begin n_fail++; $display("FAIL single_flags: got sec=%b ded=%b expected 1 0", sec, ded); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || out_sec !== 1'b0 || out_ded !== 1'b0) begin n_fail++; $display("FAIL idle_flags: got valid=%b sec=%b ded=%b expected 0 0 0", out_valid, out_sec, out_ded); end
`ifdef SECDED_ERR_CNT_EN
        n_checks++; if (cnt_sec !== 16'd1) begin n_fail++; $display("FAIL single_cnt_sec: got %0d expected 1", cnt_sec); end
`endif
    endtask

    task automatic test_double();
        logic [31:0] d; logic [6:0] sy; logic sec, ded; int lat;
        logic [38:0] code;
        code = encode(32'd8456);
        code[3] = ~code[3];
        code[5] = ~code[5];
        run_word(code, d, sy, sec, ded, lat);
        n_checks++; if (d !== 32'd8459) begin n_fail++; $display("FAIL double_raw_data: got %0d expected 8459", d); end
        n_checks++; if (sy !== 7'b0000110) begin n_fail++; $display("FAIL double_synd: got %b expected 0000110", sy); end
        n_checks++; if (sec !== 1'b0 || ded !== 1'b1) begin n_fail++; $display("FAIL double_flags: got sec=%b ded=%b expected 0 1", sec, ded); end
        @(negedge clk);
`ifdef SECDED_ERR_CNT_EN
        n_checks++; if (cnt_ded !== 16'd1 || cnt_sec !== 16'd1) begin n_fail++; $display("FAIL double_counters: got sec=%0d ded=%0d expected 1 1", cnt_sec, cnt_ded); end
`endif
    endtask

    // Boundary classifications: parity-bit error, check-bit error, top data
    // position, even-weight error pointing inside the word, odd error past 38.
    task automatic test_boundaries();
        logic [31:0] tdata [6];
        logic [38:0] tflip [6];
        logic [31:0] edata [6];
        logic [6:0]  esynd [6];
        logic        esec  [6];
        logic        eded  [6];
        logic [31:0] d; logic [6:0] sy; logic sec, ded; int lat;
        tdata[0] = 32'd8456;       tflip[0] = 39'h1;
        edata[0] = 32'd8456;       esynd[0] = 7'b1000000; esec[0] = 1'b1; eded[0] = 1'b0;
        tdata[1] = 32'hDEADBEEF;   tflip[1] = 39'h1 << 32;
        edata[1] = 32'hDEADBEEF;   esynd[1] = 7'b1100000; esec[1] = 1'b1; eded[1] = 1'b0;
        tdata[2] = 32'hDEADBEEF;   tflip[2] = 39'h1 << 38;
        edata[2] = 32'hDEADBEEF;   esynd[2] = 7'b1100110; esec[2] = 1'b1; eded[2] = 1'b0;
        tdata[3] = 32'hDEADBEEF;   tflip[3] = (39'h1 << 36) | (39'h1 << 2);
        edata[3] = 32'hFEADBEEF;   esynd[3] = 7'b0100110; esec[3] = 1'b0; eded[3] = 1'b1;
        tdata[4] = 32'd8456;       tflip[4] = (39'h1 << 32) | (39'h1 << 16) | (39'h1 << 15);
        edata[4] = 32'd9480;       esynd[4] = 7'b1111111; esec[4] = 1'b0; eded[4] = 1'b1;
        tdata[5] = 32'hFFFFFFFF;   tflip[5] = 39'h0;
        edata[5] = 32'hFFFFFFFF;   esynd[5] = 7'b0000000; esec[5] = 1'b0; eded[5] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            run_word(encode(tdata[t]) ^ tflip[t], d, sy, sec, ded, lat);
            n_checks++; if (d !== edata[t]) begin n_fail++; $display("FAIL boundary%0d_data: got %h expected %h", t, d, edata[t]); end
            n_checks++; if (sy !== esynd[t]) begin n_fail++; $display("FAIL boundary%0d_synd: got %b expected %b", t, sy, esynd[t]); end
            n_checks++; if (sec !== esec[t] || ded !== eded[t]) begin n_fail++; $display("FAIL boundary%0d_flags: got sec=%b ded=%b expected %b %b", t, sec, ded, esec[t], eded[t]); end
        end
        @(negedge clk);
    endtask

    // Four words streamed back to back with out_ready low in cycles 2..5.
    task automatic test_back_to_back();
        logic [31:0] wd [4];
        int idx, nout;
        logic accepted;
        wd[0] = 32'h01234567; wd[1] = 32'h89ABCDEF; wd[2] = 32'h0F0F0F0F; wd[3] = 32'hA5A5A5A5;
        idx = 0; nout = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (idx < 4);
            in_code   = encode(wd[(idx < 4) ? idx : 0]);
            #1;
            if (c <= 1) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b expected 1", c, in_ready); end
            end
            if (c >= 2 && c <= 5) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, in_ready); end
                n_checks++; if (out_valid !== 1'b1 || out_data !== wd[0]) begin n_fail++; $display("FAIL bp_hold_c%0d: got valid=%b data=%h expected 1 %h", c, out_valid, out_data, wd[0]); end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (nout < 4) begin
                    n_checks++; if (out_data !== wd[nout] || out_sec !== 1'b0 || out_ded !== 1'b0) begin n_fail++; $display("FAIL bp_word%0d: got %h sec=%b ded=%b expected %h 0 0", nout, out_data, out_sec, out_ded, wd[nout]); end
                end
                nout++;
            end
            accepted = in_valid && in_ready;
            @(negedge clk);
            if (accepted) idx++;
        end
        in_valid = 1'b0;
        n_checks++; if (nout !== 4) begin n_fail++; $display("FAIL bp_word_count: got %0d expected 4", nout); end
        n_checks++; if (idx !== 4) begin n_fail++; $display("FAIL bp_accept_count: got %0d expected 4", idx); end
    endtask

`ifdef SECDED_ERR_CNT_EN
    task automatic test_saturation();
        logic [38:0] code;
        int nx;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        n_checks++; if (cnt_sec !== 16'd0 || cnt_ded !== 16'd0) begin n_fail++; $display("FAIL clr_counters: got %0d %0d expected 0 0", cnt_sec, cnt_ded); end
        code = encode(32'd8456);
        code[5] = ~code[5];
        in_code = code; in_valid = 1'b1; out_ready = 1'b1;
        nx = 0;
        for (int c = 0; c < 70000 && nx < 65537; c++) begin
            #1;
            if (out_valid === 1'b1 && out_ready === 1'b1) nx++;
            @(negedge clk);
        end
        n_checks++; if (nx !== 65537) begin n_fail++; $display("FAIL sat_transfer_count: got %0d expected 65537", nx); end
        n_checks++; if (cnt_sec !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt_sec: got %h expected ffff", cnt_sec); end
        cnt_clr = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_sec !== 1'b1) begin n_fail++; $display("FAIL clr_same_cycle_xfer: got valid=%b sec=%b expected 1 1", out_valid, out_sec); end
        @(negedge clk);
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (cnt_sec !== 16'd0) begin n_fail++; $display("FAIL clr_wins: got %0d expected 0", cnt_sec); end
        repeat (4) @(negedge clk);
    endtask
`endif

    task automatic test_reset_midstream();
        logic [38:0] code;
        int nout;
        code = encode(32'h12345678);
        code[20] = ~code[20];
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        in_code = code; in_valid = 1'b1;
        @(negedge clk);
        in_code = code ^ 39'h3;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_sec !== 1'b0 || out_ded !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got sec=%b ded=%b expected 0 0", out_sec, out_ded); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        nout = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid === 1'b1) nout++;
            @(negedge clk);
        end
        n_checks++; if (nout !== 0) begin n_fail++; $display("FAIL midrst_no_output: got %0d words expected 0", nout); end
`ifdef SECDED_ERR_CNT_EN
        n_checks++; if (cnt_sec !== 16'd0 || cnt_ded !== 16'd0) begin n_fail++; $display("FAIL midrst_counters: got %0d %0d expected 0 0", cnt_sec, cnt_ded); end
`endif
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_boundaries();
        test_back_to_back();
`ifdef SECDED_ERR_CNT_EN
        test_saturation();
`endif
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/secded_stream_decoder.md
SECDED_STREAM_DECODER -- requirements
Module: secded_stream_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear on rst rising regardless of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_code  input  39  received codeword.
REQ-005 in_valid  input  1  in_code valid this cycle.
REQ-006 in_ready  output  1  block accepts in_code this cycle.
REQ-007 out_data  output  32  corrected data word.
REQ-008 out_synd  output  7  {overall parity, 6-bit Hamming syndrome} of the word on out_data.
REQ-009 out_sec  output  1  single error corrected in out_data.
REQ-010 out_ded  output  1  uncorrectable error; out_data is raw and not corrected.
REQ-011 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-012 cnt_clr  input  1  synchronous clear of the error counters.
REQ-013 cnt_sec, cnt_ded  output  16 each  error counters; present only with SECDED_ERR_CNT_EN.

Function
REQ-014 Codeword format SHALL be: in_code[i], i=1..38, is Hamming position i; check bits at positions 1,2,4,8,16,32; data bits 0..31 at the remaining positions in ascending order; in_code[0] is even parity over in_code[38:1].
REQ-015 Syndrome s[5:0] SHALL be the XOR of the indices i (1..38) where in_code[i]=1; p SHALL be the XOR of all 39 bits; out_synd = {p, s}.
REQ-016 Classification SHALL be: p=0,s=0 -> clean; p=1,s in 1..38 -> flip bit s, sec=1; p=1,s=0 -> parity bit error, data unchanged, sec=1; p=0,s!=0 -> ded=1; p=1,s>38 -> ded=1.
REQ-017 out_sec and out_ded SHALL never be 1 in the same cycle.
REQ-018 Pipeline SHALL have two register stages: S1 registers the codeword, s and p; S2 registers the corrected data and flags.
REQ-019 Latency SHALL be 2 cycles from the in_valid&in_ready edge to out_valid with no backpressure, with throughput of 1 word/cycle.
REQ-020 A stage SHALL load when it is empty or its contents move downstream in the same cycle; in_ready = !S1_valid | S1 advances.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_synd, out_sec and out_ded SHALL hold stable, and no word SHALL be dropped or duplicated.
REQ-022 Outputs with out_valid=0 SHALL be don't-care, but the flags SHALL be driven to 0.

Reset
REQ-023 On rst: S1 and S2 valid=0, out_valid=0, out_data=0, out_synd=0, out_sec=0, out_ded=0, and counters=0.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-025 Words in flight when rst asserts SHALL be discarded and SHALL NOT be counted.

Configuration
REQ-026 Macro SECDED_ERR_CNT_EN, when defined, SHALL include cnt_sec and cnt_ded.
REQ-027 With the macro, a counter SHALL increment by 1 when an out_valid&out_ready transfer has the matching flag set.
REQ-028 With the macro, counters SHALL saturate at 16'hFFFF.
REQ-029 With the macro, cnt_clr SHALL win over a same-cycle increment, and the result SHALL be 0.
REQ-030 Without the macro, the ports and counter logic SHALL be absent, and datapath behaviour SHALL be identical.

Verification
REQ-031 Clean word: encode data 32'd8456, out_ready=1 -> after 2 cycles out_data=32'd8456, out_synd=0, sec=0, ded=0.
REQ-032 Single error: same codeword with bit 13 flipped -> out_data=32'd8456, out_synd=7'b1001101, sec=1, cnt_sec=1.
REQ-033 Double error: bits 3 and 5 flipped -> out_synd[6]=0, out_synd[5:0]=6, ded=1, cnt_ded=1, out_data is the raw data field.
REQ-034 Backpressure: stream of 4 words with out_ready low for cycles 2-5 -> in_ready drops after S1 and S2 fill, and all 4 words emerge in order, unchanged.
REQ-035 Saturation and clear: force 65537 sec transfers -> cnt_sec=16'hFFFF; cnt_clr with a same-cycle sec transfer -> 0.
REQ-036 Reset mid-stream: assert rst with 2 words in flight -> out_valid=0 immediately, no output after release, and counters=0.
